struct_cmd_arbiter: RTL and testbench
=====================================

# struct_cmd_arbiter

Round-robin arbiter and sequencer that shares one single-port resource between `N` requesters. Each requester presents a packed command struct: an operation enum plus a 10-bit address and 10-bit data. The block grants one command at a time, drives the resource handshake through a small enum-typed state machine, and returns a tagged one-cycle response. It sits between the requester ports and the shared register/memory resource.

## Interface
Parameters:
- `N`, default 4: number of requesters, 2..8.
- `IDW`, default `$clog2(N)`: requester ID width.
- `TIMEOUT`, default 16: WAIT-state cycle limit. Used only with the timeout macro; range 1..255.

Ports:
- `i_clk`  input  1  clock; all logic is on the rising edge.
- `i_rst_n`  input  1  reset, asynchronous, active-low.
- `i_req_valid`  input  N  per-requester command valid.
- `o_req_ready`  output  N  per-requester accept; one-hot or zero.
- `i_req_cmd`  input  N×22  per-requester packed struct `{op[1:0], addr[9:0], data[9:0]}`.
  - Requester k occupies bits [22k+21:22k].
  - `op` enum: `OP_READ`=2'd0, `OP_WRITE`=2'd1, `OP_NOP`=2'd2, `OP_RSVD`=2'd3.
- `o_rsc_valid`  output  1  resource command valid.
- `i_rsc_ready`  input  1  resource accepts command.
- `o_rsc_write`  output  1  1 = write, 0 = read.
- `o_rsc_addr`  output  10  resource address.
- `o_rsc_wdata`  output  10  resource write data.
- `i_rsc_done`  input  1  resource completion pulse.
- `i_rsc_rdata`  input  10  read data, valid when `i_rsc_done`=1.
- `o_rsp_valid`  output  1  response pulse.
- `o_rsp_id`  output  IDW  ID of the requester being answered.
- `o_rsp_data`  output  10  read data; 0 for write and NOP.
- `o_rsp_err`  output  1  error flag: `OP_RSVD` or timeout.
- `o_busy`  output  1  state ≠ IDLE.

## Operation
- State enum `S_IDLE`, `S_ISSUE`, `S_WAIT`, `S_RESP`, encoded in 2 bits.
- **IDLE, arbitration:**
  - Search from round-robin pointer `ptr` upward, modulo N. The first requester with valid set wins.
  - `o_req_ready[win]`=1, combinational from `i_req_valid`; all other ready bits are 0.
  - On acceptance (valid & ready): latch the command and `win`, and set `ptr <= win+1` modulo N.
  - `ptr` holds when no request is present.
- **Next state after acceptance:**
  - `OP_READ` or `OP_WRITE`: go to ISSUE.
  - `OP_NOP`: go to RESP with err=0.
  - `OP_RSVD`: go to RESP with err=1.
- **ISSUE:**
  - `o_rsc_valid`=1, with write/addr/wdata taken from the latched command.
  - Hold all of them stable until `i_rsc_ready`=1, then go to WAIT.
- **WAIT:**
  - On `i_rsc_done`: capture `i_rsc_rdata` for a read (0 for a write) and go to RESP.
  - A `i_rsc_done` seen in ISSUE or IDLE is ignored.
- **RESP:** `o_rsp_valid`=1 for exactly one cycle with the latched ID, data and err, then go to IDLE. There is no response backpressure.
- At most one command is outstanding. No request is accepted outside IDLE, and `o_req_ready`=0 outside IDLE.
- Reset, including mid-operation:
  - State returns to IDLE and `ptr`=0.
  - All outputs go to 0 immediately; the latched command and response fields clear to 0.
  - Any in-flight command is dropped with no response.

## Timing
- Requester handshake accepted at cycle T.
- `o_rsc_valid` goes high at T+1.
- Resource handshake at cycle R (R ≥ T+1) → WAIT from R+1.
- `i_rsc_done` sampled at D (D ≥ R+1) → `o_rsp_valid` at D+1 → IDLE at D+2. The next acceptance can occur at D+2.
- Best-case read/write: accept at T, response at T+3, when `i_rsc_ready` and `i_rsc_done` are each high on their first eligible cycle.
- NOP/RSVD: accept at T, response at T+1.
- Simultaneous requests are resolved strictly by `ptr`. Fairness bound: a requester that holds valid waits at most N−1 grants.

## Configuration
- Macro: `STRUCT_CMD_ARBITER_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit counter clears on WAIT entry and increments each WAIT cycle without `i_rsc_done`.
  - When the count reaches `TIMEOUT`, go to RESP with err=1 and data=0.
  - If `i_rsc_done` arrives on the same cycle, done wins and err=0.
  - A late `i_rsc_done` arriving after the timeout is ignored.
- **Not defined:** no counter. WAIT persists until `i_rsc_done`. Err is set only for `OP_RSVD`.

## Test plan
- Reset with all inputs 0 → all outputs 0, `o_busy`=0. Assert `i_rst_n`=0 during WAIT → state returns to IDLE and no `o_rsp_valid` is issued.
- Requester 2 issues READ addr=0x155; resource ready immediately and done one cycle later with rdata=0x2AA → `o_rsc_addr`=0x155, `o_rsc_write`=0; response id=2, data=0x2AA, err=0 at T+3.
- All 4 requesters hold valid with WRITEs → grant order 0,1,2,3,0; each `o_rsp_id` matches; `o_rsc_wdata` matches each struct's data.
- `i_rsc_ready` held low for 5 cycles in ISSUE → `o_rsc_valid`, addr and wdata stay stable for all 5 cycles; no second `o_req_ready` is asserted.
- Requester 1 issues NOP, then requester 3 issues RSVD → responses one cycle after each acceptance: (id=1, err=0, data=0) then (id=3, err=1); `o_rsc_valid` never asserts.
- With the macro defined, TIMEOUT=4 and no `i_rsc_done` → err=1 response 4 cycles after WAIT entry. A subsequent late `i_rsc_done` produces no response.

Source files
------------

// File: rtl/struct_cmd_arbiter_if.sv
// Requester, resource and response signals of struct_cmd_arbiter.
// master drives the i_* side, slave is the arbiter itself.
interface struct_cmd_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
);
    logic [N-1:0]    i_req_valid;
    logic [N-1:0]    o_req_ready;
    logic [N*22-1:0] i_req_cmd;
    logic            o_rsc_valid;
    logic            i_rsc_ready;
    logic            o_rsc_write;
    logic [9:0]      o_rsc_addr;
    logic [9:0]      o_rsc_wdata;
    logic            i_rsc_done;
    logic [9:0]      i_rsc_rdata;
    logic            o_rsp_valid;
    logic [IDW-1:0]  o_rsp_id;
    logic [9:0]      o_rsp_data;
    logic            o_rsp_err;
    logic            o_busy;

    modport master (
        output i_req_valid, i_req_cmd, i_rsc_ready,
        output i_rsc_done, i_rsc_rdata,
        input  o_req_ready, o_rsc_valid, o_rsc_write,
        input  o_rsc_addr, o_rsc_wdata, o_rsp_valid,
        input  o_rsp_id, o_rsp_data, o_rsp_err, o_busy
    );

    modport slave (
        input  i_req_valid, i_req_cmd, i_rsc_ready,
        input  i_rsc_done, i_rsc_rdata,
        output o_req_ready, o_rsc_valid, o_rsc_write,
        output o_rsc_addr, o_rsc_wdata, o_rsp_valid,
        output o_rsp_id, o_rsp_data, o_rsp_err, o_busy
    );
endinterface

// File: rtl/struct_cmd_arbiter.sv
// Round-robin arbiter sharing one single-port resource among N requesters.
// Optional WAIT timeout enabled by defining STRUCT_CMD_ARBITER_TIMEOUT_EN.
module struct_cmd_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = $clog2(N),
    parameter int TIMEOUT = 16
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    struct_cmd_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_NOP   = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef struct packed {
        op_e        op;
        logic [9:0] addr;
        logic [9:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e         state;
    state_e         state_nxt;
    cmd_t           cmds [N];
    cmd_t           sel_cmd;
    cmd_t           cmd_q;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] win;
    logic           found;
    logic           accept;
    logic [2*N-1:0] vv;
    logic [N-1:0]   rot;
    logic [IDW-1:0] rsp_id_q;
    logic [9:0]     rsp_data_q;
    logic           rsp_err_q;
    logic           tmo_hit;

    // Split the flat command bus into per-requester structs
    always_comb begin
        for (int k = 0; k < N; k++) begin
            cmds[k] = cmd_t'(bus.i_req_cmd[22*k +: 22]);
        end
    end

    // Rotate valids by ptr and pick the first set bit as the winner
    always_comb begin
        vv    = {bus.i_req_valid, bus.i_req_valid};
        rot   = N'(vv >> ptr);
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr) + i) % N);
            end
        end
        sel_cmd = '0;
        for (int j = 0; j < N; j++) begin
            if (IDW'(j) == win) sel_cmd = cmds[j];
        end
        ptr_nxt = (win == IDW'(N-1)) ? '0 : win + IDW'(1);
        accept  = (state == S_IDLE) && found;
    end

`ifdef STRUCT_CMD_ARBITER_TIMEOUT_EN
    logic [7:0] cnt;

    // Count WAIT cycles without completion; cleared while issuing
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= 8'd0;
        end else if (state == S_ISSUE) begin
            cnt <= 8'd0;
        end else if (state == S_WAIT && !bus.i_rsc_done) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tmo_hit = (state == S_WAIT) && !bus.i_rsc_done &&
                     (cnt == 8'(TIMEOUT - 1));
`else
    logic unused_timeout;

    assign unused_timeout = |8'(TIMEOUT);
    assign tmo_hit        = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (found) begin
                    if (sel_cmd.op == OP_READ || sel_cmd.op == OP_WRITE)
                        state_nxt = S_ISSUE;
                    else
                        state_nxt = S_RESP;
                end
            end
            S_ISSUE: begin
                if (bus.i_rsc_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.i_rsc_done || tmo_hit) state_nxt = S_RESP;
            end
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Latch the granted command and build the response fields
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr        <= '0;
            cmd_q      <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                ptr        <= ptr_nxt;
                cmd_q      <= sel_cmd;
                rsp_id_q   <= win;
                rsp_data_q <= '0;
                rsp_err_q  <= (sel_cmd.op == OP_RSVD);
            end
            if (state == S_WAIT && bus.i_rsc_done) begin
                rsp_data_q <= (cmd_q.op == OP_READ) ? bus.i_rsc_rdata : '0;
            end
            if (tmo_hit) begin
                rsp_err_q <= 1'b1;
            end
        end
    end

    assign bus.o_req_ready = accept ? ({{(N-1){1'b0}}, 1'b1} << win) : '0;
    assign bus.o_rsc_valid = (state == S_ISSUE);
    assign bus.o_rsc_write = (cmd_q.op == OP_WRITE);
    assign bus.o_rsc_addr  = cmd_q.addr;
    assign bus.o_rsc_wdata = cmd_q.data;
    assign bus.o_rsp_valid = (state == S_RESP);
    assign bus.o_rsp_id    = rsp_id_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_rsp_err   = rsp_err_q;
    assign bus.o_busy      = (state != S_IDLE);

endmodule

// File: tb/tb_struct_cmd_arbiter.sv
// Directed self-checking bench for struct_cmd_arbiter (N=4, TIMEOUT=4).
// Timeout scenario runs when STRUCT_CMD_ARBITER_TIMEOUT_EN is defined.
module tb_struct_cmd_arbiter;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_NOP   = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    struct_cmd_arbiter_if #(.N(4), .IDW(2)) bus ();

    struct_cmd_arbiter #(.N(4), .IDW(2), .TIMEOUT(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] mk(input logic [1:0] op,
                                       input logic [9:0] a,
                                       input logic [9:0] d);
        return {op, a, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_req_valid = '0;
        bus.i_req_cmd   = '0;
        bus.i_rsc_ready = 1'b0;
        bus.i_rsc_done  = 1'b0;
        bus.i_rsc_rdata = '0;
        #3;
        n_chk++;
        if ({bus.o_rsc_valid, bus.o_rsc_write, bus.o_rsp_valid,
             bus.o_rsp_err, bus.o_busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_ctrl got %b exp 00000",
                     {bus.o_rsc_valid, bus.o_rsc_write, bus.o_rsp_valid,
                      bus.o_rsp_err, bus.o_busy});
        end
        n_chk++;
        if (bus.o_req_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_ready got %b exp 0000", bus.o_req_ready);
        end
        n_chk++;
        if ({bus.o_rsc_addr, bus.o_rsc_wdata, bus.o_rsp_data,
             bus.o_rsp_id} !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_data got %h exp 0",
                     {bus.o_rsc_addr, bus.o_rsc_wdata, bus.o_rsp_data,
                      bus.o_rsp_id});
        end
        step();
        rst_n = 1'b1;
        step();
        #1;
        n_chk++;
        if (bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_idle busy got %b exp 0", bus.o_busy);
        end
    endtask

    task automatic test_read();
        step();
        bus.i_req_valid = 4'b0100;
        bus.i_req_cmd[44 +: 22] = mk(OP_READ, 10'h155, 10'h0AB);
        #1;
        n_chk++;
        if (bus.o_req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL rd_ready got %b exp 0100", bus.o_req_ready);
        end
        step();
        bus.i_req_valid = '0;
        bus.i_rsc_ready = 1'b1;
        #1;
        n_chk++;
        if ({bus.o_rsc_valid, bus.o_rsc_write} !== 2'b10) begin
            n_fail++;
            $display("FAIL rd_issue got %b exp 10",
                     {bus.o_rsc_valid, bus.o_rsc_write});
        end
        n_chk++;
        if (bus.o_rsc_addr !== 10'h155) begin
            n_fail++;
            $display("FAIL rd_addr got %h exp 155", bus.o_rsc_addr);
        end
        step();
        bus.i_rsc_ready = 1'b0;
        bus.i_rsc_done  = 1'b1;
        bus.i_rsc_rdata = 10'h2AA;
        #1;
        n_chk++;
        if ({bus.o_rsc_valid, bus.o_busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL rd_wait got %b exp 01",
                     {bus.o_rsc_valid, bus.o_busy});
        end
        step();
        bus.i_rsc_done  = 1'b0;
        bus.i_rsc_rdata = '0;
        #1;
        n_chk++;
        if ({bus.o_rsp_valid, bus.o_rsp_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL rd_rsp got %b exp 10",
                     {bus.o_rsp_valid, bus.o_rsp_err});
        end
        n_chk++;
        if (bus.o_rsp_id !== 2'd2) begin
            n_fail++;
            $display("FAIL rd_id got %0d exp 2", bus.o_rsp_id);
        end
        n_chk++;
        if (bus.o_rsp_data !== 10'h2AA) begin
            n_fail++;
            $display("FAIL rd_data got %h exp 2aa", bus.o_rsp_data);
        end
        step();
        #1;
        n_chk++;
        if ({bus.o_rsp_valid, bus.o_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL rd_done got %b exp 00",
                     {bus.o_rsp_valid, bus.o_busy});
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        step();
        for (int k = 0; k < 4; k++) begin
            bus.i_req_cmd[22*k +: 22] =
                mk(OP_WRITE, 10'(16 + k), 10'(256 + k));
        end
        bus.i_req_valid = 4'hF;
        for (int g = 0; g < 5; g++) begin
            int e;
            e = g % 4;
            #1;
            n_chk++;
            if (bus.o_req_ready !== 4'(1 << e)) begin
                n_fail++;
                $display("FAIL rr_grant%0d got %b exp %b",
                         g, bus.o_req_ready, 4'(1 << e));
            end
            step();
            bus.i_rsc_ready = 1'b1;
            #1;
            n_chk++;
            if (bus.o_rsc_wdata !== 10'(256 + e)) begin
                n_fail++;
                $display("FAIL rr_wdata%0d got %h exp %h",
                         g, bus.o_rsc_wdata, 10'(256 + e));
            end
            n_chk++;
            if ({bus.o_rsc_valid, bus.o_rsc_write,
                 bus.o_rsc_addr} !== {2'b11, 10'(16 + e)}) begin
                n_fail++;
                $display("FAIL rr_issue%0d got %h exp %h", g,
                         {bus.o_rsc_valid, bus.o_rsc_write, bus.o_rsc_addr},
                         {2'b11, 10'(16 + e)});
            end
            step();
            bus.i_rsc_ready = 1'b0;
            bus.i_rsc_done  = 1'b1;
            bus.i_rsc_rdata = 10'h3FF;
            step();
            bus.i_rsc_done  = 1'b0;
            bus.i_rsc_rdata = '0;
            #1;
            n_chk++;
            if ({bus.o_rsp_valid, bus.o_rsp_err,
                 bus.o_rsp_data} !== 12'h800) begin
                n_fail++;
                $display("FAIL rr_rsp%0d got %h exp 800", g,
                         {bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_data});
            end
            n_chk++;
            if (bus.o_rsp_id !== 2'(e)) begin
                n_fail++;
                $display("FAIL rr_id%0d got %0d exp %0d",
                         g, bus.o_rsp_id, e);
            end
            step();
        end
        bus.i_req_valid = '0;
    endtask

    task automatic test_stall();
        step();
        bus.i_req_valid = 4'b1010;
        bus.i_req_cmd[22 +: 22] = mk(OP_WRITE, 10'h3C3, 10'h1E1);
        bus.i_req_cmd[66 +: 22] = mk(OP_READ, 10'h011, 10'h000);
        #1;
        n_chk++;
        if (bus.o_req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL st_grant got %b exp 0010", bus.o_req_ready);
        end
        step();
        bus.i_req_valid = 4'b1000;
        bus.i_rsc_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_chk++;
            if ({bus.o_rsc_valid, bus.o_rsc_write, bus.o_rsc_addr,
                 bus.o_rsc_wdata, bus.o_req_ready} !==
                {2'b11, 10'h3C3, 10'h1E1, 4'b0000}) begin
                n_fail++;
                $display("FAIL st_hold%0d got %h exp %h", i,
                         {bus.o_rsc_valid, bus.o_rsc_write, bus.o_rsc_addr,
                          bus.o_rsc_wdata, bus.o_req_ready},
                         {2'b11, 10'h3C3, 10'h1E1, 4'b0000});
            end
            step();
        end
        bus.i_rsc_ready = 1'b1;
        step();
        bus.i_rsc_ready = 1'b0;
        bus.i_rsc_done  = 1'b1;
        #1;
        n_chk++;
        if (bus.o_req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL st_wait_ready got %b exp 0000", bus.o_req_ready);
        end
        step();
        bus.i_rsc_done = 1'b0;
        #1;
        n_chk++;
        if ({bus.o_rsp_valid, bus.o_rsp_id} !== 3'b101) begin
            n_fail++;
            $display("FAIL st_rsp got %b exp 101",
                     {bus.o_rsp_valid, bus.o_rsp_id});
        end
        step();
        #1;
        n_chk++;
        if (bus.o_req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL st_next got %b exp 1000", bus.o_req_ready);
        end
        bus.i_req_valid = '0;
    endtask

    task automatic test_nop_rsvd();
        step();
        bus.i_req_valid = 4'b0010;
        bus.i_req_cmd[22 +: 22] = mk(OP_NOP, 10'h3FF, 10'h3FF);
        #1;
        n_chk++;
        if ({bus.o_req_ready, bus.o_rsc_valid} !== 5'b00100) begin
            n_fail++;
            $display("FAIL nop_grant got %b exp 00100",
                     {bus.o_req_ready, bus.o_rsc_valid});
        end
        step();
        bus.i_req_valid = 4'b1000;
        bus.i_req_cmd[66 +: 22] = mk(OP_RSVD, 10'h001, 10'h002);
        #1;
        n_chk++;
        if ({bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_id,
             bus.o_rsp_data} !== {2'b10, 2'd1, 10'h000}) begin
            n_fail++;
            $display("FAIL nop_rsp got %h exp %h",
                     {bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_id,
                      bus.o_rsp_data}, {2'b10, 2'd1, 10'h000});
        end
        n_chk++;
        if ({bus.o_req_ready, bus.o_rsc_valid} !== 5'b00000) begin
            n_fail++;
            $display("FAIL nop_busy got %b exp 00000",
                     {bus.o_req_ready, bus.o_rsc_valid});
        end
        step();
        #1;
        n_chk++;
        if ({bus.o_req_ready, bus.o_rsc_valid,
             bus.o_rsp_valid} !== 6'b100000) begin
            n_fail++;
            $display("FAIL rsv_grant got %b exp 100000",
                     {bus.o_req_ready, bus.o_rsc_valid, bus.o_rsp_valid});
        end
        step();
        bus.i_req_valid = '0;
        #1;
        n_chk++;
        if ({bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_id,
             bus.o_rsc_valid} !== 5'b11110) begin
            n_fail++;
            $display("FAIL rsv_rsp got %b exp 11110",
                     {bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_id,
                      bus.o_rsc_valid});
        end
        step();
        #1;
        n_chk++;
        if ({bus.o_rsp_valid, bus.o_busy, bus.o_rsc_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL rsv_idle got %b exp 000",
                     {bus.o_rsp_valid, bus.o_busy, bus.o_rsc_valid});
        end
    endtask

    task automatic test_reset_mid();
        step();
        bus.i_req_valid = 4'b0001;
        bus.i_req_cmd[0 +: 22] = mk(OP_READ, 10'h2F0, 10'h000);
        step();
        bus.i_req_valid = '0;
        bus.i_rsc_ready = 1'b1;
        step();
        bus.i_rsc_ready = 1'b0;
        #1;
        n_chk++;
        if ({bus.o_busy, bus.o_rsc_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL rm_wait got %b exp 10",
                     {bus.o_busy, bus.o_rsc_valid});
        end
        rst_n = 1'b0;
        bus.i_rsc_done  = 1'b1;
        bus.i_rsc_rdata = 10'h3FF;
        #1;
        n_chk++;
        if ({bus.o_busy, bus.o_rsc_valid, bus.o_rsp_valid, bus.o_rsp_err,
             bus.o_rsc_addr, bus.o_rsp_id, bus.o_rsp_data} !== 26'h0) begin
            n_fail++;
            $display("FAIL rm_outs got %h exp 0",
                     {bus.o_busy, bus.o_rsc_valid, bus.o_rsp_valid,
                      bus.o_rsp_err, bus.o_rsc_addr, bus.o_rsp_id,
                      bus.o_rsp_data});
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            n_chk++;
            if ({bus.o_rsp_valid, bus.o_busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL rm_norsp%0d got %b exp 00", i,
                         {bus.o_rsp_valid, bus.o_busy});
            end
        end
        bus.i_rsc_done  = 1'b0;
        bus.i_rsc_rdata = '0;
        bus.i_req_valid = 4'b1001;
        #1;
        n_chk++;
        if (bus.o_req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rm_ptr got %b exp 0001", bus.o_req_ready);
        end
        bus.i_req_valid = '0;
    endtask

`ifdef STRUCT_CMD_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        step();
        bus.i_req_valid = 4'b0100;
        bus.i_req_cmd[44 +: 22] = mk(OP_READ, 10'h0F0, 10'h000);
        step();
        bus.i_req_valid = '0;
        bus.i_rsc_ready = 1'b1;
        step();
        bus.i_rsc_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++;
            if ({bus.o_rsp_valid, bus.o_busy} !== 2'b01) begin
                n_fail++;
                $display("FAIL to_wait%0d got %b exp 01", i,
                         {bus.o_rsp_valid, bus.o_busy});
            end
            step();
        end
        #1;
        n_chk++;
        if ({bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_id,
             bus.o_rsp_data} !== {2'b11, 2'd2, 10'h000}) begin
            n_fail++;
            $display("FAIL to_rsp got %h exp %h",
                     {bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_id,
                      bus.o_rsp_data}, {2'b11, 2'd2, 10'h000});
        end
        step();
        bus.i_rsc_done  = 1'b1;
        bus.i_rsc_rdata = 10'h155;
        #1;
        n_chk++;
        if (bus.o_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL to_late got %b exp 0", bus.o_rsp_valid);
        end
        step();
        bus.i_rsc_done  = 1'b0;
        bus.i_rsc_rdata = '0;
        #1;
        n_chk++;
        if ({bus.o_rsp_valid, bus.o_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL to_idle got %b exp 00",
                     {bus.o_rsp_valid, bus.o_busy});
        end
    endtask
`else
    task automatic test_wait_hold();
        step();
        bus.i_req_valid = 4'b0100;
        bus.i_req_cmd[44 +: 22] = mk(OP_READ, 10'h0F0, 10'h000);
        step();
        bus.i_req_valid = '0;
        bus.i_rsc_ready = 1'b1;
        step();
        bus.i_rsc_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            n_chk++;
            if ({bus.o_rsp_valid, bus.o_busy} !== 2'b01) begin
                n_fail++;
                $display("FAIL wh_wait%0d got %b exp 01", i,
                         {bus.o_rsp_valid, bus.o_busy});
            end
            step();
        end
        bus.i_rsc_done  = 1'b1;
        bus.i_rsc_rdata = 10'h0CC;
        step();
        bus.i_rsc_done  = 1'b0;
        bus.i_rsc_rdata = '0;
        #1;
        n_chk++;
        if ({bus.o_rsp_valid, bus.o_rsp_err,
             bus.o_rsp_data} !== {2'b10, 10'h0CC}) begin
            n_fail++;
            $display("FAIL wh_rsp got %h exp %h",
                     {bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_data},
                     {2'b10, 10'h0CC});
        end
    endtask
`endif

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_read();
        test_round_robin();
        test_stall();
        test_nop_rsvd();
        test_reset_mid();
`ifdef STRUCT_CMD_ARBITER_TIMEOUT_EN
        test_timeout();
`else
        test_wait_hold();
`endif
        step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
